// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu shared types: funct3 size codes, FSM states and access width.
// Build option: LSU_MISALIGN_TRAP_EN enables the misaligned-access trap.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_width_t;

    // Unused size codes (3, 6, 7) fall through to word accesses.
    function automatic lsu_width_t size_width(logic [2:0] size);
        lsu_width_t w;
        w = SZ_WORD;
        if (size == LDST_B || size == LDST_BU)
            w = SZ_BYTE;
        else if (size == LDST_H || size == LDST_HU)
            w = SZ_HALF;
        return w;
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Word-aligned data-memory port between the LSU (master) and memory (slave).
interface riscv_lsu_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_be_o,
        output mem_addr_o,
        output mem_wd_o,
        input  mem_rd_i,
        input  mem_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_addr_o,
        input  mem_wd_o,
        output mem_rd_i,
        output mem_ready_i
    );

endinterface

// File: rtl/riscv_lsu_load_fmt.sv
// Load formatter: shifts the read word down to the addressed lane and
// sign- or zero-extends it according to the funct3 size code.
module riscv_lsu_load_fmt
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    logic [31:0] sh;

    assign sh = rd >> {off, 3'b000};

    always_comb begin
        data = sh;
        case (size)
            LDST_B:  data = {{24{sh[7]}}, sh[7:0]};
            LDST_BU: data = {24'd0, sh[7:0]};
            LDST_H:  data = {{16{sh[15]}}, sh[15:0]};
            LDST_HU: data = {16'd0, sh[15:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: byte/half/word core requests to word-aligned memory
// transactions. Build option: LSU_MISALIGN_TRAP_EN adds misalign_o.
module riscv_lsu
    import riscv_lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    riscv_lsu_if.master mem
);

    lsu_state_t  state_q;
    lsu_state_t  state_d;
    lsu_width_t  width;
    logic [1:0]  off;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] fmt_rd;
    logic        accept;
    logic        trap;

    assign width  = size_width(core_size_i);
    assign accept = (state_q == IDLE) & core_req_i;

    // Misaligned halfword/word offsets are truncated to natural alignment.
    always_comb begin
        off = core_addr_i[1:0];
        be  = 4'b1111;
        wd  = core_wd_i;
        case (width)
            SZ_BYTE: begin
                be = 4'b0001 << core_addr_i[1:0];
                wd = {4{core_wd_i[7:0]}};
            end
            SZ_HALF: begin
                off = {core_addr_i[1], 1'b0};
                be  = 4'b0011 << {core_addr_i[1], 1'b0};
                wd  = {2{core_wd_i[15:0]}};
            end
            default: off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((width == SZ_HALF) & core_addr_i[0])
                | ((width == SZ_WORD) & (|core_addr_i[1:0]));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (core_req_i) state_d = trap ? DONE : BUSY;
            BUSY: if (mem.mem_ready_i) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem.mem_req_o  <= 1'b0;
            mem.mem_we_o   <= 1'b0;
            mem.mem_be_o   <= 4'b0000;
            mem.mem_addr_o <= 32'd0;
            mem.mem_wd_o   <= 32'd0;
            size_q         <= 3'd0;
            off_q          <= 2'd0;
        end else begin
            mem.mem_req_o <= (state_d == BUSY);
            if (accept) begin
                mem.mem_we_o   <= core_we_i;
                mem.mem_be_o   <= be;
                mem.mem_addr_o <= {core_addr_i[31:2], 2'b00};
                mem.mem_wd_o   <= wd;
                size_q         <= core_size_i;
                off_q          <= off;
            end
        end
    end

    riscv_lsu_load_fmt u_load_fmt (
        .rd   (mem.mem_rd_i),
        .size (size_q),
        .off  (off_q),
        .data (fmt_rd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            core_rd_o <= 32'd0;
        else if (state_q == BUSY && mem.mem_ready_i && !mem.mem_we_o)
            core_rd_o <= fmt_rd;
        else if (accept && trap)
            core_rd_o <= 32'd0;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            misalign_o <= 1'b0;
        else
            misalign_o <= accept & trap;
    end
`endif

    assign core_stall_o = core_req_i & (state_q != DONE);

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomised self-checking bench for riscv_lsu against a byte-lane model.
// Build option: LSU_MISALIGN_TRAP_EN selects the trapping variant.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;
    bit [31:0] last_rd;

    riscv_lsu_if mem_if ();

    riscv_lsu dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_o   (misalign),
`endif
        .mem          (mem_if.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access. Expectations come from a per-byte-lane view:
    // a size covers nb lanes starting at the naturally aligned offset.
    task automatic access(input bit we, input bit [2:0] sz,
                          input bit [31:0] a, input bit [31:0] wd,
                          input bit [31:0] rw, input int dly);
        int nb, off, nreq, nst, cyc;
        bit sx, mis, done;
        bit [3:0] ebe, cap_be;
        bit [31:0] ewd, erd, cap_addr, cap_wd;
        bit cap_we;
        longint v;
        nb = (sz == 0 || sz == 4) ? 1 : (sz == 1 || sz == 5) ? 2 : 4;
        sx = (sz == 0 || sz == 1);
        off = int'(a[1:0]);
        off = off / nb * nb;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (off != int'(a[1:0]));
`endif
        for (int i = 0; i < 4; i++) begin
            ebe[i] = (i >= off) && (i < off + nb);
            ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        v = longint'(rw >> (8 * off)) % (longint'(1) << (8 * nb));
        if (sx && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        erd = v[31:0];
        if (mis)
            erd = 32'd0;
        else if (we)
            erd = last_rd;

        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = a;
        core_wd_i   = wd;
        mem_if.mem_rd_i = rw;
        nreq = 0; nst = 0; cyc = 0; done = 1'b0;
        cap_addr = '0; cap_be = '0; cap_wd = '0; cap_we = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1)
                chk("rd_hold", core_rd_o, last_rd);
            if (mem_if.mem_req_o) begin
                if (nreq == 0) begin
                    cap_addr = mem_if.mem_addr_o;
                    cap_be   = mem_if.mem_be_o;
                    cap_wd   = mem_if.mem_wd_o;
                    cap_we   = mem_if.mem_we_o;
                end
                mem_if.mem_ready_i = (nreq == dly);
                nreq++;
            end else begin
                mem_if.mem_ready_i = 1'($urandom);
            end
            if (core_stall_o) nst++;
            else done = 1'b1;
        end
        if (!done) chk("timeout", 32'(core_stall_o), 32'd0);
        chk("rd", core_rd_o, erd);
        if (mis) begin
            chk("nreq_trap", 32'(nreq), 32'd0);
            chk("stall_trap", 32'(nst), 32'd1);
        end else begin
            chk("nreq", 32'(nreq), 32'(dly + 1));
            chk("stall", 32'(nst), 32'(dly + 2));
            chk("addr", cap_addr, a - 32'(a[1:0]));
            chk("be", 32'(cap_be), 32'(ebe));
            chk("wd", cap_wd, ewd);
            chk("we", 32'(cap_we), 32'(we));
        end
`ifdef LSU_MISALIGN_TRAP_EN
        chk("misalign", 32'(misalign), 32'(mis));
`endif
        last_rd = erd;
        @(posedge clk_i);
        #1;
        core_req_i = 1'b0;
        mem_if.mem_ready_i = 1'b0;
    endtask

    initial begin
        bit [31:0] r;
        rst_ni = 1'b0;
        core_req_i = 1'b0;
        core_we_i = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = '0;
        core_wd_i = '0;
        mem_if.mem_rd_i = '0;
        mem_if.mem_ready_i = 1'b0;
        last_rd = '0;
        #12;
        chk("rst_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_if.mem_we_o), 32'd0);
        chk("rst_be", 32'(mem_if.mem_be_o), 32'd0);
        chk("rst_addr", mem_if.mem_addr_o, 32'd0);
        chk("rst_wd", mem_if.mem_wd_o, 32'd0);
        chk("rst_rd", core_rd_o, 32'd0);
        chk("rst_stall0", 32'(core_stall_o), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rst_mis", 32'(misalign), 32'd0);
`endif
        core_req_i = 1'b1;
        #1;
        chk("rst_stall1", 32'(core_stall_o), 32'd1);
        core_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        access(1'b1, 3'd0, 32'h1002, 32'hAABBCCDD, 32'h0, 0);
        access(1'b0, 3'd0, 32'h2001, 32'hFFFF_FFFF, 32'h12348056, 0);
        access(1'b0, 3'd4, 32'h2001, 32'h0, 32'h12348056, 1);
        access(1'b0, 3'd1, 32'h2002, 32'h0, 32'h9ABC0000, 0);
        access(1'b1, 3'd0, 32'h2003, 32'h1234_5678, 32'hDEAD_BEEF, 2);
        access(1'b0, 3'd5, 32'h2002, 32'h0, 32'h9ABC0000, 2);
        access(1'b0, 3'd2, 32'h4000, 32'h0, 32'hCAFE_F00D, 3);
        access(1'b1, 3'd2, 32'h3002, 32'h1122_3344, 32'h0, 0);
        access(1'b0, 3'd1, 32'h5001, 32'h0, 32'h8001_7FFE, 1);

        // Reset while BUSY: memory request must drop without a clock edge.
        core_req_i = 1'b1;
        core_we_i = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h6000;
        mem_if.mem_rd_i = 32'h5555_AAAA;
        mem_if.mem_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("busy_req", 32'(mem_if.mem_req_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("arst_stall", 32'(core_stall_o), 32'd1);
        chk("arst_rd", core_rd_o, 32'd0);
        core_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        last_rd = '0;
        access(1'b0, 3'd2, 32'h7000, 32'h0, 32'h0BAD_CAFE, 0);

        repeat (80) begin
            r = $urandom;
            access(r[0], r[3:1], $urandom, $urandom, $urandom,
                   int'(r[7:4]) % 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the `core` data-memory port and the data memory. It accepts one byte, halfword or word request per instruction from the core and converts it into a word-aligned memory transaction with byte enables and lane-replicated write data. Read data is aligned and sign- or zero-extended before it is returned. The core is stalled until the memory answers, which gives the single-cycle core a multi-cycle memory handshake.

## Interface
Parameters:
- none; widths are fixed at 32-bit data and 32-bit address.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `core_req_i`  in  1  core requests a memory access; held stable while `core_stall_o` is high.
- `core_we_i`  in  1  1 = store, 0 = load.
- `core_size_i`  in  3  funct3 size code.
- `core_addr_i`  in  32  byte address.
- `core_wd_i`  in  32  store data, right-justified.
- `core_rd_o`  out  32  formatted load data; valid while state is DONE.
- `core_stall_o`  out  1  core must hold `pc` and the instruction.
- `misalign_o`  out  1  misaligned-access pulse; exists only when the macro is compiled in.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  memory write.
- `mem_be_o`  out  4  byte enables.
- `mem_addr_o`  out  32  word address; bits [1:0] are always 0.
- `mem_wd_o`  out  32  lane-replicated write data.
- `mem_rd_i`  in  32  memory read word.
- `mem_ready_i`  in  1  memory completes the request this cycle.

## Operation
- Size codes:
  - 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
  - 3, 6 and 7 behave as W.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: on `core_req_i`. The address, be, wd, we, size and addr[1:0] are registered.
  - BUSY → DONE: on `mem_ready_i`. The formatted `mem_rd_i` is captured into the `core_rd_o` register; stores capture nothing.
  - DONE → IDLE: unconditionally.
- Stall: `core_stall_o = core_req_i & (state != DONE)`. The core commits the load/store at the end of the DONE cycle.
- Byte enables:
  - B/BU: `4'b0001 << a[1:0]`.
  - H/HU: `4'b0011 << {a[1],1'b0}`.
  - W: `4'b1111`.
  - Loads drive the same `mem_be_o` as stores.
- Write data:
  - B: `{4{wd[7:0]}}`.
  - H: `{2{wd[15:0]}}`.
  - W: `wd`.
- Load data:
  - The read word is shifted right by `8*a[1:0]`.
  - B and H are sign-extended from bit 7 and bit 15; BU and HU are zero-extended.
- `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wd_o` are registered. They are valid only in BUSY; `mem_req_o` is 0 in every other state.
- `core_rd_o` holds its last value outside DONE.

## Timing
- Reset values:
  - state IDLE.
  - `mem_req_o`, `mem_we_o` = 0; `mem_be_o` = 0; `mem_addr_o`, `mem_wd_o`, `core_rd_o` = 0.
  - `misalign_o` = 0.
  - `core_stall_o` follows `core_req_i`.
- Minimum latency is 3 cycles:
  - request seen in cycle N (IDLE);
  - `mem_req_o` high in N+1;
  - if ready in N+1, DONE and stall low in N+2.
- Every cycle of `mem_ready_i` low in BUSY adds one cycle.
- `mem_ready_i` is ignored outside BUSY.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE, so throughput is one access per 3 cycles minimum.
- Reset mid-BUSY: `mem_req_o` drops immediately (asynchronous). The transaction is abandoned and no data is returned.
- `core_req_i` falling while in BUSY is a protocol violation; the LSU still completes the access.

## Configuration
- `LSU_MISALIGN_TRAP_EN`, defined:
  - A request counts as misaligned when H/HU has a[0]=1, or W has a[1:0]≠0.
  - A misaligned request in IDLE goes directly to DONE, with no `mem_req_o`.
  - `misalign_o` = 1 for that DONE cycle, and `core_rd_o` = 0.
- `LSU_MISALIGN_TRAP_EN`, undefined:
  - The `misalign_o` port is absent.
  - Misaligned addresses are truncated to natural alignment (H ignores a[0], W ignores a[1:0]) and the access proceeds normally.

## Structure
- `riscv_lsu_pkg` holds:
  - size localparams `LDST_B`, `LDST_H`, `LDST_W`, `LDST_BU`, `LDST_HU`;
  - the state enum `lsu_state_t`.
- Sub-module `riscv_lsu_load_fmt`: a combinational shift-and-extend unit taking rd, size and a[1:0] and producing the formatted load data. It is instantiated once.

## Test plan
- SB, addr 0x1002, wd 0xAABBCCDD, ready in first BUSY cycle:
  - `mem_addr_o`=0x1000, `mem_be_o`=0100, `mem_wd_o`=0xDDDDDDDD;
  - stall high for 2 cycles.
- LB, addr 0x2001, `mem_rd_i` 0x12348056: `core_rd_o`=0xFFFFFF80. LBU at the same address gives 0x00000080.
- LH, addr 0x2002, `mem_rd_i` 0x9ABC0000: `core_rd_o`=0xFFFF9ABC. LHU gives 0x00009ABC.
- LW with `mem_ready_i` delayed 3 cycles: `mem_req_o` held 4 cycles; stall low exactly in the DONE cycle; `core_rd_o` equals `mem_rd_i`.
- `rst_ni` asserted in BUSY: `mem_req_o`=0 with no clock edge; state IDLE; a new request after release completes in 3 cycles.
- SW addr 0x3002:
  - with `LSU_MISALIGN_TRAP_EN`: no `mem_req_o`, `misalign_o` pulses once, stall 1 cycle;
  - without it: `mem_addr_o`=0x3000, be=1111.
